// File: rtl/cache_ctrl_param.sv
// cache_ctrl_param
//    Direct-mapped, write-through, no-write-allocate cache controller that sits
//    between a pipeline stage (CPU side) and a variable-latency memory port.
//
// Parameters
//    AW     address width
//    DW     data width
//    LINES  number of lines (power of 2, >= 2)
//    CW     width of the saturating hit/miss counters
//
// Ports
//    i_clk, i_reset (async, active low)
//    CPU side : i_cpu_req, o_cpu_ready, i_cpu_we, i_cpu_addr, i_cpu_wdata,
//               o_cpu_done (1-cycle pulse), o_cpu_rdata (held after done)
//    control  : i_flush (level, sampled while ready), o_busy
//    memory   : o_mem_req (held until i_mem_ack), o_mem_we, o_mem_addr,
//               o_mem_wdata, i_mem_rdata, i_mem_ack
//    stats    : o_hit_cnt, o_miss_cnt
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | accepting requests; read hits complete here at 1 per cycle
// S_RD_MISS | memory read outstanding, line refilled on i_mem_ack
// S_WR_THRU | memory write outstanding, cached copy updated on ack if hit
// S_FLUSH   | clearing one valid bit per cycle, LINES cycles total

module cache_ctrl_param #(
   parameter int AW    = 8,
   parameter int DW    = 32,
   parameter int LINES = 16,
   parameter int CW    = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_cpu_req,
   output logic          o_cpu_ready,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   output logic          o_cpu_done,
   output logic [DW-1:0] o_cpu_rdata,
   input  logic          i_flush,
   output logic          o_busy,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   input  logic          i_mem_ack,
   output logic [CW-1:0] o_hit_cnt,
   output logic [CW-1:0] o_miss_cnt
);

   localparam int IDX = $clog2(LINES);
   localparam int TAG = AW - IDX;
   localparam logic [IDX-1:0] LAST_IDX = IDX'(LINES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_MISS,
      S_WR_THRU,
      S_FLUSH
   } state_t;

   // Registered state
   state_t           r_state;
   logic [LINES-1:0] r_valid;
   logic [IDX-1:0]   r_fcnt;
   logic             r_wr_hit;
   logic             r_done;
   logic [DW-1:0]    r_rdata;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;
   logic [CW-1:0]    r_hit_cnt;
   logic [CW-1:0]    r_miss_cnt;

   // Line storage; only the valid bits need a reset value
   logic [TAG-1:0]   r_tag_mem  [LINES];
   logic [DW-1:0]    r_data_mem [LINES];

   // Combinational lookup and next-state values
   logic [IDX-1:0]   w_idx;
   logic [TAG-1:0]   w_tag;
   logic             w_hit;

   state_t           w_state_nx;
   logic [LINES-1:0] w_valid_nx;
   logic [IDX-1:0]   w_fcnt_nx;
   logic             w_wr_hit_nx;
   logic             w_done_nx;
   logic [DW-1:0]    w_rdata_nx;
   logic             w_mem_req_nx;
   logic             w_mem_we_nx;
   logic [AW-1:0]    w_mem_addr_nx;
   logic [DW-1:0]    w_mem_wdata_nx;
   logic             w_hit_inc;
   logic             w_miss_inc;
   logic [CW-1:0]    w_hit_cnt_nx;
   logic [CW-1:0]    w_miss_cnt_nx;

   logic             w_line_we;
   logic [IDX-1:0]   w_line_idx;
   logic [TAG-1:0]   w_line_tag;
   logic [DW-1:0]    w_line_data;

   assign w_idx = i_cpu_addr[IDX-1:0];
   assign w_tag = i_cpu_addr[AW-1:IDX];
   assign w_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

   always_comb begin
      w_state_nx     = r_state;
      w_valid_nx     = r_valid;
      w_fcnt_nx      = r_fcnt;
      w_wr_hit_nx    = r_wr_hit;
      w_done_nx      = 1'b0;
      w_rdata_nx     = r_rdata;
      w_mem_req_nx   = r_mem_req;
      w_mem_we_nx    = r_mem_we;
      w_mem_addr_nx  = r_mem_addr;
      w_mem_wdata_nx = r_mem_wdata;
      w_hit_inc      = 1'b0;
      w_miss_inc     = 1'b0;
      // Line updates always target the address latched for the memory access
      w_line_we      = 1'b0;
      w_line_idx     = r_mem_addr[IDX-1:0];
      w_line_tag     = r_mem_addr[AW-1:IDX];
      w_line_data    = i_mem_rdata;

      unique case (r_state)
         S_IDLE: begin
            if (i_flush) begin
               // flush wins over a simultaneous request
               w_fcnt_nx  = '0;
               w_state_nx = S_FLUSH;
            end else if (i_cpu_req) begin
               if (i_cpu_we) begin
                  w_mem_req_nx   = 1'b1;
                  w_mem_we_nx    = 1'b1;
                  w_mem_addr_nx  = i_cpu_addr;
                  w_mem_wdata_nx = i_cpu_wdata;
                  // remember hit status now: the line is refreshed only on ack
                  w_wr_hit_nx    = w_hit;
                  w_hit_inc      = w_hit;
                  w_miss_inc     = !w_hit;
                  w_state_nx     = S_WR_THRU;
               end else if (w_hit) begin
                  w_rdata_nx = r_data_mem[w_idx];
                  w_done_nx  = 1'b1;
                  w_hit_inc  = 1'b1;
               end else begin
                  w_mem_req_nx  = 1'b1;
                  w_mem_we_nx   = 1'b0;
                  w_mem_addr_nx = i_cpu_addr;
                  w_miss_inc    = 1'b1;
                  w_state_nx    = S_RD_MISS;
               end
            end
         end

         S_RD_MISS: begin
            if (i_mem_ack) begin
               w_line_we              = 1'b1;
               w_valid_nx[w_line_idx] = 1'b1;
               w_rdata_nx             = i_mem_rdata;
               w_done_nx              = 1'b1;
               w_mem_req_nx           = 1'b0;
               w_state_nx             = S_IDLE;
            end
         end

         S_WR_THRU: begin
            if (i_mem_ack) begin
               if (r_wr_hit) begin
                  w_line_we   = 1'b1;
                  w_line_data = r_mem_wdata;
               end
               w_done_nx    = 1'b1;
               w_mem_req_nx = 1'b0;
               w_state_nx   = S_IDLE;
            end
         end

         S_FLUSH: begin
            w_valid_nx[r_fcnt] = 1'b0;
            w_fcnt_nx          = r_fcnt + 1'b1;
            if (r_fcnt == LAST_IDX) begin
               w_state_nx = S_IDLE;
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      w_hit_cnt_nx  = (w_hit_inc && (r_hit_cnt != '1)) ? r_hit_cnt + 1'b1 : r_hit_cnt;
      w_miss_cnt_nx = (w_miss_inc && (r_miss_cnt != '1)) ? r_miss_cnt + 1'b1 : r_miss_cnt;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_valid     <= '0;
         r_fcnt      <= '0;
         r_wr_hit    <= 1'b0;
         r_done      <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_valid     <= w_valid_nx;
         r_fcnt      <= w_fcnt_nx;
         r_wr_hit    <= w_wr_hit_nx;
         r_done      <= w_done_nx;
         r_rdata     <= w_rdata_nx;
         r_mem_req   <= w_mem_req_nx;
         r_mem_we    <= w_mem_we_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wdata <= w_mem_wdata_nx;
         r_hit_cnt   <= w_hit_cnt_nx;
         r_miss_cnt  <= w_miss_cnt_nx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_line_we) begin
         r_tag_mem[w_line_idx]  <= w_line_tag;
         r_data_mem[w_line_idx] <= w_line_data;
      end
   end

   assign o_cpu_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_cpu_done  = r_done;
   assign o_cpu_rdata = r_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_hit_cnt   = r_hit_cnt;
   assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Scoreboard bench for cache_ctrl_param. The reference model keeps, per line,
// the full cached address and data plus a flat memory image; expected CPU
// responses and expected memory transactions are queued at accept time and
// popped by independent monitor / memory-responder processes.
module tb_cache_ctrl_param;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int LINES = 16;
   localparam int CW    = 5;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_cpu_req;
   logic          o_cpu_ready;
   logic          i_cpu_we;
   logic [AW-1:0] i_cpu_addr;
   logic [DW-1:0] i_cpu_wdata;
   logic          o_cpu_done;
   logic [DW-1:0] o_cpu_rdata;
   logic          i_flush;
   logic          o_busy;
   logic          o_mem_req;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_ack;
   logic [CW-1:0] o_hit_cnt;
   logic [CW-1:0] o_miss_cnt;

   always #5 clk = ~clk;

   cache_ctrl_param #(.AW(AW), .DW(DW), .LINES(LINES), .CW(CW)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_cpu_req(i_cpu_req), .o_cpu_ready(o_cpu_ready), .i_cpu_we(i_cpu_we),
      .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
      .o_cpu_done(o_cpu_done), .o_cpu_rdata(o_cpu_rdata),
      .i_flush(i_flush), .o_busy(o_busy),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
      .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
   );

   typedef struct {
      bit            rd;
      logic [DW-1:0] rdata;
      int            hits;
      int            misses;
   } exp_t;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_t;

   exp_t sq[$];
   mem_t mq[$];

   // reference model
   bit            m_valid [LINES];
   logic [AW-1:0] m_addr  [LINES];
   logic [DW-1:0] m_data  [LINES];
   logic [DW-1:0] tb_mem  [256];
   int            m_hits;
   int            m_misses;

   int checks   = 0;
   int failures = 0;
   int done_seen = 0;
   bit hold_ack = 1'b0;
   bit fake_ack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int   n;
      int   li;
      bit   hit;
      exp_t e;
      mem_t m;
      n = 0;
      @(negedge clk);
      while (!o_cpu_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!o_cpu_ready) begin
         check("issue_ready_timeout", 64'(o_cpu_ready), 64'd1);
         return;
      end
      i_cpu_req   = 1'b1;
      i_cpu_we    = we;
      i_cpu_addr  = a;
      i_cpu_wdata = d;
      @(posedge clk);
      li  = int'(a) % LINES;
      hit = m_valid[li] && (m_addr[li] == a);
      if (hit) begin
         if (m_hits < CMAX) m_hits++;
      end else begin
         if (m_misses < CMAX) m_misses++;
      end
      if (we) begin
         tb_mem[a] = d;
         if (hit) m_data[li] = d;
         m = '{we: 1'b1, addr: a, wdata: d};
         mq.push_back(m);
         e = '{rd: 1'b0, rdata: '0, hits: m_hits, misses: m_misses};
      end else if (hit) begin
         e = '{rd: 1'b1, rdata: m_data[li], hits: m_hits, misses: m_misses};
      end else begin
         m_valid[li] = 1'b1;
         m_addr[li]  = a;
         m_data[li]  = tb_mem[a];
         m = '{we: 1'b0, addr: a, wdata: '0};
         mq.push_back(m);
         e = '{rd: 1'b1, rdata: tb_mem[a], hits: m_hits, misses: m_misses};
      end
      sq.push_back(e);
      #1 i_cpu_req = 1'b0;
   endtask

   task automatic do_flush(input bit with_req);
      int n;
      int cnt;
      n = 0;
      @(negedge clk);
      while (!o_cpu_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!o_cpu_ready) begin
         check("flush_ready_timeout", 64'(o_cpu_ready), 64'd1);
         return;
      end
      i_flush    = 1'b1;
      i_cpu_req  = with_req;
      i_cpu_we   = 1'b0;
      i_cpu_addr = 8'h23;
      @(posedge clk);
      #1;
      i_flush   = 1'b0;
      i_cpu_req = 1'b0;
      model_clear();
      cnt = 0;
      while (cnt < 100) begin
         @(negedge clk);
         if (!o_busy) break;
         cnt++;
         check("flush_ready_low", 64'(o_cpu_ready), 64'd0);
         check("flush_no_memreq", 64'(o_mem_req), 64'd0);
      end
      check("flush_busy_cycles", 64'(cnt), 64'(LINES));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sq.size() != 0 || mq.size() != 0 || !o_cpu_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_timeout", 64'(sq.size() + mq.size()), 64'd0);
   endtask

   // CPU response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_cpu_done) begin
            done_seen++;
            if (sq.size() == 0) begin
               check("done_unexpected", 64'(o_cpu_done), 64'd0);
            end else begin
               e = sq.pop_front();
               if (e.rd) check("done_rdata", 64'(o_cpu_rdata), 64'(e.rdata));
               check("done_hit_cnt", 64'(o_hit_cnt), 64'(e.hits));
               check("done_miss_cnt", 64'(o_miss_cnt), 64'(e.misses));
            end
         end
      end
   end

   // memory responder with random latency
   initial begin
      mem_t          m;
      int            lat;
      logic [AW-1:0] a0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (fake_ack) begin
            i_mem_rdata = $urandom;
            i_mem_ack   = 1'b1;
            @(negedge clk);
            i_mem_ack = 1'b0;
            fake_ack  = 1'b0;
         end else if (o_mem_req && !hold_ack && i_reset) begin
            a0 = o_mem_addr;
            if (mq.size() == 0) begin
               check("mem_unexpected", 64'(o_mem_req), 64'd0);
            end else begin
               m = mq.pop_front();
               check("mem_we", 64'(o_mem_we), 64'(m.we));
               check("mem_addr", 64'(o_mem_addr), 64'(m.addr));
               if (m.we) check("mem_wdata", 64'(o_mem_wdata), 64'(m.wdata));
            end
            lat = $urandom_range(0, 4);
            repeat (lat) begin
               @(negedge clk);
               check("mem_req_held", 64'(o_mem_req), 64'd1);
               check("mem_addr_stable", 64'(o_mem_addr), 64'(a0));
            end
            i_mem_rdata = o_mem_we ? DW'($urandom) : tb_mem[o_mem_addr];
            i_mem_ack   = 1'b1;
            @(negedge clk);
            i_mem_ack = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      i_reset     = 1'b0;
      i_cpu_req   = 1'b0;
      i_cpu_we    = 1'b0;
      i_cpu_addr  = '0;
      i_cpu_wdata = '0;
      i_flush     = 1'b0;
      m_hits      = 0;
      m_misses    = 0;
      model_clear();
      for (int i = 0; i < 256; i++) tb_mem[i] = $urandom;
      tb_mem[8'h23] = 32'hDEADBEEF;
      tb_mem[8'h33] = 32'h11111111;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(o_cpu_ready), 64'd1);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_cpu_done), 64'd0);
      check("rst_rdata", 64'(o_cpu_rdata), 64'd0);
      check("rst_mem_req", 64'(o_mem_req), 64'd0);
      check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
      check("rst_hit_cnt", 64'(o_hit_cnt), 64'd0);
      check("rst_miss_cnt", 64'(o_miss_cnt), 64'd0);
      @(negedge clk);
      i_reset = 1'b1;

      // read miss
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t1_rdata", 64'(o_cpu_rdata), 64'hDEADBEEF);
      check("t1_miss_cnt", 64'(o_miss_cnt), 64'd1);

      // back-to-back read hits
      issue(1'b0, 8'h23, '0);
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t2_hit_cnt", 64'(o_hit_cnt), 64'd2);
      check("t2_rdata", 64'(o_cpu_rdata), 64'hDEADBEEF);

      // conflict eviction
      issue(1'b0, 8'h33, '0);
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t3_miss_cnt", 64'(o_miss_cnt), 64'd3);
      check("t3_hit_cnt", 64'(o_hit_cnt), 64'd2);

      // write-through hit, then no-allocate miss
      issue(1'b1, 8'h23, 32'h12345678);
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t4_rdata", 64'(o_cpu_rdata), 64'h12345678);
      check("t4_hit_cnt", 64'(o_hit_cnt), 64'd4);
      issue(1'b1, 8'h44, 32'hCAFEF00D);
      issue(1'b0, 8'h44, '0);
      wait_idle();
      check("t4_miss_cnt", 64'(o_miss_cnt), 64'd5);
      check("t4_rdata44", 64'(o_cpu_rdata), 64'hCAFEF00D);

      // flush with simultaneous request
      do_flush(1'b1);
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t5_miss_cnt", 64'(o_miss_cnt), 64'd6);

      // reset during a read miss, late ack ignored
      hold_ack = 1'b1;
      issue(1'b0, 8'h60, '0);
      repeat (2) @(negedge clk);
      check("t6_mem_req", 64'(o_mem_req), 64'd1);
      check("t6_mem_addr", 64'(o_mem_addr), 64'h60);
      check("t6_mem_we", 64'(o_mem_we), 64'd0);
      @(posedge clk);
      #2 i_reset = 1'b0;
      #1;
      check("t6_rst_mem_req", 64'(o_mem_req), 64'd0);
      check("t6_rst_miss_cnt", 64'(o_miss_cnt), 64'd0);
      check("t6_rst_hit_cnt", 64'(o_hit_cnt), 64'd0);
      check("t6_rst_busy", 64'(o_busy), 64'd0);
      sq.delete();
      mq.delete();
      model_clear();
      m_hits   = 0;
      m_misses = 0;
      @(negedge clk);
      i_reset = 1'b1;
      d0 = done_seen;
      fake_ack = 1'b1;
      n = 0;
      while (fake_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("t6_late_ack_no_done", 64'(done_seen - d0), 64'd0);
      check("t6_late_ack_idle", 64'(o_busy), 64'd0);
      hold_ack = 1'b0;
      issue(1'b0, 8'h23, '0);
      wait_idle();
      check("t6_miss_cnt", 64'(o_miss_cnt), 64'd1);
      check("t6_hit_cnt", 64'(o_hit_cnt), 64'd0);

      // randomized traffic; counters saturate at CMAX along the way
      for (int k = 0; k < 300; k++) begin
         int r;
         logic [AW-1:0] a;
         r = $urandom_range(0, 99);
         a = AW'((($urandom % 4) << 4) | ($urandom % 16));
         if (r < 4) do_flush(1'($urandom % 2));
         else if (r < 30) issue(1'b1, a, DW'($urandom));
         else issue(1'b0, a, '0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle();
      check("final_hit_cnt", 64'(o_hit_cnt), 64'(m_hits));
      check("final_miss_cnt", 64'(o_miss_cnt), 64'(m_misses));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
